// File: rtl/bcd_serial_subtractor.sv
// Digit-serial packed-BCD subtractor: |A - B| one digit per clock, LSD first, sign reported separately.
// Optional invalid-digit checking and the err port are enabled by defining BCD_SUB_VALID_CHECK_EN.
module bcd_serial_subtractor #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   a,
   input  logic [4*DIGITS-1:0]   b,
   output logic                  ready,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   diff,
`ifdef BCD_SUB_VALID_CHECK_EN
   output logic                  neg,
   output logic                  err
`else
   output logic                  neg
`endif
);

   localparam int W  = 4 * DIGITS;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SUB,
      S_FIX,
      S_FIN,
      S_DONE
   } state_t;

   state_t          state_q;
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;
   logic [3:0]      res_q [DIGITS];
   logic            borrow_q;
   logic [IW-1:0]   idx_q;
   logic            busy_q;
   logic            done_q;
   logic [W-1:0]    diff_q;
   logic            neg_q;
   logic            neg_pend_q;
   logic            flag;

   logic [3:0]      a_dig   [DIGITS];
   logic [3:0]      b_dig   [DIGITS];
   logic [W-1:0]    res_flat;
   logic            last_dig;

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_dig
         assign a_dig[gi]             = a_q[4*gi +: 4];
         assign b_dig[gi]             = b_q[4*gi +: 4];
         assign res_flat[4*gi +: 4]   = res_q[gi];
      end
   endgenerate

`ifdef BCD_SUB_VALID_CHECK_EN
   logic            flag_q;
   logic            err_q;
   logic [DIGITS-1:0] a_bad;
   logic [DIGITS-1:0] b_bad;

   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_chk
         assign a_bad[gi] = (a[4*gi +: 4] > 4'd9);
         assign b_bad[gi] = (b[4*gi +: 4] > 4'd9);
      end
   endgenerate

   assign flag = flag_q;
   assign err  = err_q;
`else
   assign flag = 1'b0;
`endif

   // Shared digit ALU: SUB computes a_i - b_i - borrow, FIX computes 0 - raw_i - borrow.
   logic [3:0] x_nib;
   logic [3:0] y_nib;
   logic [4:0] t;
   logic       brw;
   logic [3:0] dig;

   always_comb begin
      x_nib = 4'd0;
      y_nib = res_q[idx_q];
      if (state_q == S_SUB) begin
         x_nib = a_dig[idx_q];
         y_nib = b_dig[idx_q];
      end
      t   = {1'b0, x_nib} - {1'b0, y_nib} - {4'd0, borrow_q};
      brw = t[4];
      dig = brw ? (t[3:0] + 4'd10) : t[3:0];
   end

   assign last_dig = (idx_q == IW'(DIGITS - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         a_q        <= '0;
         b_q        <= '0;
         borrow_q   <= 1'b0;
         idx_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         diff_q     <= '0;
         neg_q      <= 1'b0;
         neg_pend_q <= 1'b0;
         for (int i = 0; i < DIGITS; i++) res_q[i] <= 4'd0;
`ifdef BCD_SUB_VALID_CHECK_EN
         flag_q     <= 1'b0;
         err_q      <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  a_q      <= a;
                  b_q      <= b;
                  borrow_q <= 1'b0;
                  idx_q    <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= S_SUB;
`ifdef BCD_SUB_VALID_CHECK_EN
                  flag_q   <= (|a_bad) | (|b_bad);
`endif
               end
            end
            S_SUB: begin
               res_q[idx_q] <= dig;
               borrow_q     <= brw;
               if (last_dig) begin
                  idx_q <= '0;
                  // A final borrow means the raw result is the ten's complement of |A-B|.
                  if (brw && !flag) begin
                     borrow_q <= 1'b0;
                     state_q  <= S_FIX;
                  end else begin
                     neg_pend_q <= 1'b0;
                     state_q    <= S_FIN;
                  end
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            S_FIX: begin
               res_q[idx_q] <= dig;
               borrow_q     <= brw;
               if (last_dig) begin
                  idx_q      <= '0;
                  borrow_q   <= 1'b0;
                  neg_pend_q <= 1'b1;
                  state_q    <= S_FIN;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            S_FIN: begin
               done_q  <= 1'b1;
               diff_q  <= flag ? '0 : res_flat;
               neg_q   <= flag ? 1'b0 : neg_pend_q;
`ifdef BCD_SUB_VALID_CHECK_EN
               err_q   <= flag_q;
`endif
               state_q <= S_DONE;
            end
            S_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign ready = ~busy_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign diff  = diff_q;
   assign neg   = neg_q;

endmodule
